// File: rtl/mips_run_monitor_pkg.sv
// Shared types and helpers for the MIPS run-control monitor.
package mips_pkg;

  localparam int DEFAULT_DATA_W = 16;

  typedef enum logic [1:0] {
    RST_HOLD = 2'd0,
    RUN      = 2'd1,
    HALT     = 2'd2,
    TIMEOUT  = 2'd3
  } run_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/mips_run_monitor_trace_fifo.sv
// First-word-fall-through trace FIFO with drop-on-full and a sticky overflow flag.
module trace_fifo
  import mips_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           push_data_i,
  input  logic                   pop_i,
  output logic                   valid_o,
  output logic [W-1:0]           head_o,
  output logic [clog2(DEPTH):0]  level_o,
  output logic                   overflow_o
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, rd_q;
  logic         overflow_q;
  logic [AW:0]  level;
  logic         empty, full, do_pop, do_push;

  // Counters carry one extra bit so full and empty stay distinguishable.
  assign level   = wr_q - rd_q;
  assign empty   = (level == '0);
  assign full    = (level == FULL_LVL);
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
    end else if (flush_i) begin
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      if (push_i && full && !do_pop) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q[AW-1:0]] <= push_data_i;
  end

  assign valid_o    = !empty;
  assign head_o     = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign level_o    = level;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/mips_run_monitor.sv
// Run control for a MIPS core: reset sequencing, cycle counting, halt/timeout
// detection and a (PC, ALU result) trace FIFO.
module mips_run_monitor
  import mips_pkg::*;
#(
  parameter int DATA_W       = DEFAULT_DATA_W,
  parameter int RESET_CYCLES = 5,
  parameter int HALT_CYCLES  = 4,
  parameter int MAX_CYCLES   = 0,
  parameter int TRACE_DEPTH  = 16,
  parameter int CNT_W        = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DATA_W-1:0]            pc_in,
  input  logic [DATA_W-1:0]            alu_in,
  input  logic                         trace_rd,
  output logic                         core_reset,
  output logic                         running,
  output logic                         halted,
  output logic                         timeout,
  output logic [CNT_W-1:0]             cycle_count,
  output logic                         trace_valid,
  output logic [DATA_W-1:0]            trace_pc,
  output logic [DATA_W-1:0]            trace_alu,
  output logic [clog2(TRACE_DEPTH):0]  trace_level,
  output logic                         trace_overflow,
  output logic [1:0]                   run_state
);

  localparam int HW = clog2(RESET_CYCLES + 1);
  localparam int SW = clog2(HALT_CYCLES + 1);

  run_state_e       state_q;
  logic [HW-1:0]    hold_q;
  logic [SW-1:0]    stable_q;
  logic [CNT_W-1:0] cycle_q;
  logic [DATA_W-1:0] pc_prev_q;
  logic             first_q;
  logic             core_reset_q, running_q, halted_q, timeout_q;

  logic             pc_same, push, hit_halt, hit_timeout;
  logic [CNT_W-1:0] cycle_inc;
  logic [SW-1:0]    stable_inc;

  // pc_prev is stale on the first RUN cycle, so that sample always counts as new.
  assign pc_same     = !first_q && (pc_in == pc_prev_q);
  assign cycle_inc   = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
  assign stable_inc  = stable_q + 1'b1;
  assign hit_halt    = pc_same && (stable_inc == SW'(HALT_CYCLES));
  assign hit_timeout = (MAX_CYCLES != 0) && (cycle_inc == CNT_W'(MAX_CYCLES));
  assign push        = (state_q == RUN) && !start && !pc_same;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= RST_HOLD;
      hold_q       <= '0;
      stable_q     <= '0;
      cycle_q      <= '0;
      pc_prev_q    <= '0;
      first_q      <= 1'b1;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else if (start) begin
      state_q      <= RST_HOLD;
      hold_q       <= '0;
      stable_q     <= '0;
      cycle_q      <= '0;
      first_q      <= 1'b1;
      core_reset_q <= 1'b1;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      case (state_q)
        RST_HOLD: begin
          if (hold_q == HW'(RESET_CYCLES - 1)) begin
            state_q      <= RUN;
            hold_q       <= '0;
            first_q      <= 1'b1;
            core_reset_q <= 1'b0;
            running_q    <= 1'b1;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        RUN: begin
          cycle_q   <= cycle_inc;
          pc_prev_q <= pc_in;
          first_q   <= 1'b0;
          stable_q  <= pc_same ? stable_inc : '0;
          // Halt takes priority over a timeout landing on the same edge.
          if (hit_halt) begin
            state_q   <= HALT;
            running_q <= 1'b0;
            halted_q  <= 1'b1;
          end else if (hit_timeout) begin
            state_q   <= TIMEOUT;
            running_q <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  trace_fifo #(
    .W     (2 * DATA_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk         (clk),
    .reset       (reset),
    .flush_i     (start),
    .push_i      (push),
    .push_data_i ({pc_in, alu_in}),
    .pop_i       (trace_rd),
    .valid_o     (trace_valid),
    .head_o      ({trace_pc, trace_alu}),
    .level_o     (trace_level),
    .overflow_o  (trace_overflow)
  );

  assign core_reset  = core_reset_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign cycle_count = cycle_q;
  assign run_state   = state_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Directed bench: dut_a uses default parameters, dut_b has MAX_CYCLES=10 and a 4-entry trace.
module tb_mips_run_monitor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        trace_rd = 1'b0;
  logic [15:0] pc_in = '0;
  logic [15:0] alu_in = '0;

  logic        a_core_reset, a_running, a_halted, a_timeout, a_valid, a_overflow;
  logic [31:0] a_cycle;
  logic [15:0] a_pc, a_alu;
  logic [4:0]  a_level;
  logic [1:0]  a_state;

  logic        b_core_reset, b_running, b_halted, b_timeout, b_valid, b_overflow;
  logic [31:0] b_cycle;
  logic [15:0] b_pc, b_alu;
  logic [2:0]  b_level;
  logic [1:0]  b_state;

  int checks = 0;
  int failures = 0;

  always #10 clk = ~clk;

  mips_run_monitor dut_a (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .alu_in(alu_in),
    .trace_rd(trace_rd), .core_reset(a_core_reset), .running(a_running),
    .halted(a_halted), .timeout(a_timeout), .cycle_count(a_cycle),
    .trace_valid(a_valid), .trace_pc(a_pc), .trace_alu(a_alu),
    .trace_level(a_level), .trace_overflow(a_overflow), .run_state(a_state)
  );

  mips_run_monitor #(.MAX_CYCLES(10), .TRACE_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .alu_in(alu_in),
    .trace_rd(trace_rd), .core_reset(b_core_reset), .running(b_running),
    .halted(b_halted), .timeout(b_timeout), .cycle_count(b_cycle),
    .trace_valid(b_valid), .trace_pc(b_pc), .trace_alu(b_alu),
    .trace_level(b_level), .trace_overflow(b_overflow), .run_state(b_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset = 1'b1; start = 1'b0; trace_rd = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_hold();
    repeat (5) tick();
  endtask

  task automatic test_reset();
    checks++; if (a_core_reset !== 1'b1) begin failures++; $display("FAIL rst_core_reset got=%0b exp=1", a_core_reset); end
    checks++; if (a_running !== 1'b0) begin failures++; $display("FAIL rst_running got=%0b exp=0", a_running); end
    checks++; if ({a_halted, a_timeout, a_overflow, a_valid} !== 4'b0) begin failures++; $display("FAIL rst_flags got=%b exp=0000", {a_halted, a_timeout, a_overflow, a_valid}); end
    checks++; if (a_cycle !== 32'd0) begin failures++; $display("FAIL rst_cycle got=%0d exp=0", a_cycle); end
    checks++; if ({a_pc, a_alu, a_level} !== '0) begin failures++; $display("FAIL rst_trace got=%h/%h/%0d exp=0", a_pc, a_alu, a_level); end
    checks++; if (a_state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", a_state); end
    release_reset();
    for (int i = 1; i <= 5; i++) begin
      tick();
      if (i < 5) begin
        checks++; if (a_core_reset !== 1'b1) begin failures++; $display("FAIL hold_core_reset edge=%0d got=%0b exp=1", i, a_core_reset); end
      end else begin
        checks++; if ({a_core_reset, a_running} !== 2'b01) begin failures++; $display("FAIL hold_release got=%b exp=01", {a_core_reset, a_running}); end
      end
    end
    for (int i = 1; i <= 3; i++) begin
      pc_in = 16'(i * 4); alu_in = 16'(i);
      tick();
      checks++; if (a_cycle !== 32'(i)) begin failures++; $display("FAIL run_cycle got=%0d exp=%0d", a_cycle, i); end
    end
  endtask

  task automatic test_halt();
    release_reset();
    wait_hold();
    for (int i = 0; i < 8; i++) begin
      pc_in = (i < 4) ? 16'(i * 2) : 16'd6;
      alu_in = 16'hA000 + 16'(i);
      tick();
      if (i == 6) begin
        checks++; if ({a_halted, a_running} !== 2'b01) begin failures++; $display("FAIL halt_early got=%b exp=01", {a_halted, a_running}); end
      end
    end
    checks++; if ({a_halted, a_running, a_timeout} !== 3'b100) begin failures++; $display("FAIL halt_flags got=%b exp=100", {a_halted, a_running, a_timeout}); end
    checks++; if (a_cycle !== 32'd8) begin failures++; $display("FAIL halt_cycle got=%0d exp=8", a_cycle); end
    pc_in = 16'd8;
    tick();
    tick();
    checks++; if (a_cycle !== 32'd8) begin failures++; $display("FAIL halt_frozen got=%0d exp=8", a_cycle); end
    checks++; if (a_level !== 5'd4) begin failures++; $display("FAIL halt_level got=%0d exp=4", a_level); end
    checks++; if (a_core_reset !== 1'b0) begin failures++; $display("FAIL halt_core_reset got=%0b exp=0", a_core_reset); end
    for (int k = 0; k < 4; k++) begin
      checks++; if ({a_pc, a_alu} !== {16'(k * 2), 16'hA000 + 16'(k)}) begin failures++; $display("FAIL halt_trace k=%0d got=%h/%h exp=%h/%h", k, a_pc, a_alu, 16'(k * 2), 16'hA000 + 16'(k)); end
      trace_rd = 1'b1;
      tick();
      trace_rd = 1'b0;
    end
    checks++; if ({a_valid, a_level, a_pc} !== '0) begin failures++; $display("FAIL halt_drained got=%b/%0d/%h exp=0", a_valid, a_level, a_pc); end
  endtask

  task automatic test_timeout();
    release_reset();
    wait_hold();
    for (int i = 0; i < 10; i++) begin
      pc_in = 16'(i * 2);
      alu_in = 16'(i);
      tick();
      if (i == 8) begin
        checks++; if ({b_running, b_timeout} !== 2'b10) begin failures++; $display("FAIL to_early got=%b exp=10", {b_running, b_timeout}); end
      end
    end
    checks++; if ({b_timeout, b_running, b_halted} !== 3'b100) begin failures++; $display("FAIL to_flags got=%b exp=100", {b_timeout, b_running, b_halted}); end
    checks++; if (b_cycle !== 32'd10) begin failures++; $display("FAIL to_cycle got=%0d exp=10", b_cycle); end
    checks++; if (b_state !== 2'd3) begin failures++; $display("FAIL to_state got=%0d exp=3", b_state); end
    pc_in = 16'h0100;
    tick();
    tick();
    checks++; if (b_cycle !== 32'd10 || b_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%0d/%0b exp=10/1", b_cycle, b_timeout); end
    checks++; if (a_running !== 1'b1) begin failures++; $display("FAIL nolimit_running got=%0b exp=1", a_running); end
  endtask

  task automatic test_timeout_halt();
    release_reset();
    wait_hold();
    for (int i = 0; i < 10; i++) begin
      pc_in = (i < 6) ? 16'(i * 2) : 16'd10;
      alu_in = 16'(i);
      tick();
      if (i == 8) begin
        checks++; if ({b_halted, b_timeout, b_running} !== 3'b001) begin failures++; $display("FAIL toh_early got=%b exp=001", {b_halted, b_timeout, b_running}); end
      end
    end
    checks++; if ({b_halted, b_timeout} !== 2'b10) begin failures++; $display("FAIL toh_priority got=%b exp=10", {b_halted, b_timeout}); end
    checks++; if (b_cycle !== 32'd10) begin failures++; $display("FAIL toh_cycle got=%0d exp=10", b_cycle); end
  endtask

  task automatic test_overflow();
    release_reset();
    wait_hold();
    for (int i = 0; i < 6; i++) begin
      pc_in = 16'h0010 + 16'(i);
      alu_in = 16'h0020 + 16'(i);
      tick();
    end
    checks++; if ({b_level, b_overflow, b_valid} !== {3'd4, 1'b1, 1'b1}) begin failures++; $display("FAIL ovf_state got=%0d/%0b/%0b exp=4/1/1", b_level, b_overflow, b_valid); end
    checks++; if ({b_pc, b_alu} !== {16'h0010, 16'h0020}) begin failures++; $display("FAIL ovf_head got=%h/%h exp=0010/0020", b_pc, b_alu); end
    pc_in = 16'h0040; alu_in = 16'h0060; trace_rd = 1'b1;
    tick();
    checks++; if ({b_level, b_overflow} !== {3'd4, 1'b1}) begin failures++; $display("FAIL ovf_pushpop got=%0d/%0b exp=4/1", b_level, b_overflow); end
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        checks++; if ({b_pc, b_alu} !== {16'h0011 + 16'(k), 16'h0021 + 16'(k)}) begin failures++; $display("FAIL ovf_order k=%0d got=%h/%h exp=%h/%h", k, b_pc, b_alu, 16'h0011 + 16'(k), 16'h0021 + 16'(k)); end
      end else begin
        checks++; if ({b_pc, b_alu} !== {16'h0040, 16'h0060}) begin failures++; $display("FAIL ovf_tail got=%h/%h exp=0040/0060", b_pc, b_alu); end
      end
      tick();
    end
    checks++; if ({b_valid, b_level, b_pc} !== '0) begin failures++; $display("FAIL ovf_empty got=%b/%0d/%h exp=0", b_valid, b_level, b_pc); end
    tick();
    checks++; if (b_level !== 3'd0) begin failures++; $display("FAIL ovf_pop_empty got=%0d exp=0", b_level); end
    trace_rd = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({b_timeout, b_overflow, b_core_reset} !== 3'b001) begin failures++; $display("FAIL ovf_start got=%b exp=001", {b_timeout, b_overflow, b_core_reset}); end
    checks++; if (b_cycle !== 32'd0) begin failures++; $display("FAIL ovf_start_cycle got=%0d exp=0", b_cycle); end
  endtask

  task automatic test_start();
    release_reset();
    wait_hold();
    pc_in = 16'h0030; alu_in = 16'h0070; trace_rd = 1'b1;
    tick();
    trace_rd = 1'b0;
    checks++; if ({a_level, a_pc, a_alu} !== {5'd1, 16'h0030, 16'h0070}) begin failures++; $display("FAIL st_empty_pushpop got=%0d/%h/%h exp=1/0030/0070", a_level, a_pc, a_alu); end
    pc_in = 16'h0031; tick();
    pc_in = 16'h0032; tick();
    checks++; if (a_level !== 5'd3) begin failures++; $display("FAIL st_level3 got=%0d exp=3", a_level); end
    pc_in = 16'h0033; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({a_valid, a_level, a_overflow} !== '0) begin failures++; $display("FAIL st_flush got=%b/%0d/%b exp=0", a_valid, a_level, a_overflow); end
    checks++; if ({a_cycle, a_core_reset, a_running} !== {32'd0, 2'b10}) begin failures++; $display("FAIL st_ctrl got=%0d/%b/%b exp=0/1/0", a_cycle, a_core_reset, a_running); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (a_core_reset !== (i < 5)) begin failures++; $display("FAIL st_hold edge=%0d got=%0b exp=%0b", i, a_core_reset, i < 5); end
    end
    pc_in = 16'h0050; tick();
    pc_in = 16'h0052; tick();
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if ({a_halted, a_core_reset, a_state} !== {2'b01, 2'd0}) begin failures++; $display("FAIL st_vs_halt got=%b/%b/%0d exp=0/1/0", a_halted, a_core_reset, a_state); end
    tick();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if (a_core_reset !== (i < 5)) begin failures++; $display("FAIL st_rehold edge=%0d got=%0b exp=%0b", i, a_core_reset, i < 5); end
    end
  endtask

  task automatic test_async_reset();
    release_reset();
    wait_hold();
    for (int i = 0; i < 3; i++) begin
      pc_in = 16'h0200 + 16'(i);
      tick();
    end
    #4;
    reset = 1'b1;
    #1;
    checks++; if ({a_core_reset, a_running, a_valid} !== 3'b100) begin failures++; $display("FAIL arst_flags got=%b exp=100", {a_core_reset, a_running, a_valid}); end
    checks++; if ({a_cycle, a_level, a_state} !== '0) begin failures++; $display("FAIL arst_counts got=%0d/%0d/%0d exp=0", a_cycle, a_level, a_state); end
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_halt();
    test_timeout();
    test_timeout_halt();
    test_overflow();
    test_start();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
